// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch PC, ROM addressing and decode-side queue
// Fetches one ROM word per cycle into a DEPTH-entry {pc, instr} FIFO; redirects flush and reload the PC.
module fetch_queue #(
  parameter int N     = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [5:0]    imem_addr,
  input  logic [IW-1:0] imem_q,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [N-1:0]  out_pc,
  output logic [N-1:0]  fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [N-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [N-1:0]  pc_mem_q    [DEPTH];
  logic [IW-1:0] instr_mem_q [DEPTH];

  logic pop;
  logic push;

  // Low PC bits never reach the fetch address; a redirect is always word-aligned.
  logic unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full queue still takes a new word when the head leaves in the same cycle.
  assign push      = !redirect_valid & ((count_q < FULL) | pop);

  assign imem_addr = pc_q[7:2];
  assign fetch_pc  = pc_q;
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[N-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        pc_d     = pc_q + N'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry contents are only meaningful while counted, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the 64-word instruction ROM (6-bit word address, 32-bit combinational read data).
- Holds the program counter and drives the ROM word address from it.
- Captures each returned instruction word together with its PC into a small FIFO.
- Presents the queue head to decode over a valid/ready handshake; redirects (branches, jumps) flush the queue and reload the PC.

Parameters:
- N, 64, PC width in bits
- IW, 32, instruction width; must match ROM data width
- DEPTH, 4, queue entries; power of two, 2 or greater

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- imem_addr  out  6  ROM word address, always equal to pc[7:2]
- imem_q  in  IW  ROM read data for imem_addr, same cycle (combinational)
- redirect_valid  in  1  load redirect_pc and flush the queue
- redirect_pc  in  N  new fetch address; bits [1:0] ignored, treated as 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  IW  head instruction
- out_pc  out  N  PC of head instruction
- fetch_pc  out  N  current PC register value (debug)

Behaviour:
- Reset asserted (asynchronous): pc=0, count=0, rd_ptr=wr_ptr=0, out_valid=0, fetch_pc=0, imem_addr=0. Contents of out_instr/out_pc are don't-care while out_valid=0.
- Storage: DEPTH entries of {pc, instr}; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH; count is 0..DEPTH.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count<DEPTH | pop). This means a full queue still accepts a push in the same cycle it pops.
- On push (clock edge):
  - Write entry[wr_ptr] = {pc, imem_q}.
  - wr_ptr+1 and pc <= pc+4 (mod 2^N; 0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- On pop: rd_ptr+1.
- count next:
  - count+1 on push only
  - count-1 on pop only
  - unchanged when both or neither occur
- Redirect (highest priority):
  - At the edge: pc <= {redirect_pc[N-1:2],2'b00}; count, rd_ptr, wr_ptr <= 0.
  - No push that cycle.
  - A pop asserted in the same cycle is still a valid handoff to decode, but the queue is emptied regardless.
  - The next cycle has out_valid=0, and the first instruction from the new PC is pushed that cycle.
- Latency: an instruction fetched at edge k is visible on out_valid/out_instr/out_pc after edge k. Redirect to first valid output is 2 edges.
- Outputs:
  - out_valid = (count!=0).
  - out_instr/out_pc = entry[rd_ptr], read combinationally from registers.
  - Head is stable while out_valid & !out_ready & !redirect_valid.
- ROM aliasing: imem_addr = pc[7:2], so PCs 256 bytes apart fetch the same word. This is intended.
- Full and stalled (count=DEPTH, out_ready=0): no push, pc holds, imem_addr holds.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. First push occurs on the first edge after reset deasserts.
- No X propagation: out_valid is never X after reset.

Test Plan:
- Stub ROM q={26'h0,addr}; reset low 2 cycles then high, out_ready=1 -> out_valid rises after first edge with out_pc=0, out_instr=0; following cycles out_pc=4,8,12 with out_instr=1,2,3.
- out_ready=0 from reset -> exactly 4 pushes, count=4, fetch_pc=16 held, head stays pc=0/instr=0; then out_ready=1 for 1 cycle -> pop and push same edge, count stays 4, fetch_pc=20, head pc=4.
- Redirect_pc=0x2E (misaligned) with a full queue -> next cycle out_valid=0, fetch_pc=0x2C; following cycle out_pc=0x2C, out_instr=0x0B.
- Redirect and pop same cycle -> head consumed once, queue empty next cycle, no stale entry ever appears on the output.
- Redirect_pc=0xFFFF_FFFF_FFFF_FFFC, out_ready=1 -> entries pc=...FFFC (instr 0x3F), then pc=0 (instr 0); imem_addr goes 63 then 0.
- Assert reset mid-stream with count=3 -> out_valid=0 and fetch_pc=0 before the next clock edge; after release, the sequence restarts at pc=0.
